// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-SRAM port arbiter.
package dmem_arb_pkg;

  // What the single SRAM port does in a given cycle.
  typedef enum logic [1:0] {
    SLOT_IDLE,
    SLOT_RD,
    SLOT_WR
  } slot_e;

  // Width of the write-buffer age counter (saturates at 15).
  localparam int AGE_W = 4;

  // Default number of lost arbitrations before a buffered write is forced out.
  localparam int STARVE_LIMIT_DEF = 4;

  // Saturating increment for the age counter.
  function automatic logic [AGE_W-1:0] age_sat_inc(input logic [AGE_W-1:0] age);
    return (age == {AGE_W{1'b1}}) ? age : age + AGE_W'(1);
  endfunction

endpackage

// File: rtl/write_buffer.sv
// One-entry posted write buffer: holds a write-back store until the SRAM
// port is free, tracks how long it has waited, and offers an address
// compare so reads can be served from the buffered word.
module write_buffer
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  accept,
  input  logic [ADDR_WIDTH-1:0] acc_addr,
  input  logic [DATA_WIDTH-1:0] acc_data,
  input  logic                  drain,
  input  logic [ADDR_WIDTH-1:0] match_addr,
  output logic                  valid,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] data,
  output logic [AGE_W-1:0]      age,
  output logic                  match
);

  logic                  valid_q, valid_d;
  logic [AGE_W-1:0]      age_q, age_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  // Next-state: drain empties the entry, a new accept (possibly in the same
  // cycle as a drain) refills it with a fresh age.
  always_comb begin
    valid_d = valid_q;
    age_d   = age_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (drain) begin
      valid_d = 1'b0;
      age_d   = '0;
    end else if (valid_q) begin
      age_d = age_sat_inc(age_q);
    end
    if (accept) begin
      valid_d = 1'b1;
      age_d   = '0;
      addr_d  = acc_addr;
      data_d  = acc_data;
    end
  end

  // Control state: reset discards any buffered write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      age_q   <= '0;
    end else begin
      valid_q <= valid_d;
      age_q   <= age_d;
    end
  end

  // Payload is qualified by valid_q, so it carries no reset.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end

  assign valid = valid_q;
  assign addr  = addr_q;
  assign data  = data_q;
  assign age   = age_q;
  assign match = valid_q && (addr_q == match_addr);

endmodule

// File: rtl/data_mem_arbiter.sv
// Data-SRAM port arbiter: shares sram1 between operand-fetch reads and
// write-back writes with a posted write buffer, fixed priority plus an
// anti-starvation override, and store-to-load forwarding.
module data_mem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 16,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_gnt,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_gnt,
  input  logic                  flush,
  output logic                  wb_pending,
  output logic [ADDR_WIDTH-1:0] addr_1,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  we_n,
  input  logic [DATA_WIDTH-1:0] data_in
);

  localparam logic [AGE_W-1:0] STARVE_AGE = AGE_W'(STARVE_LIMIT);

  logic                  buf_valid;
  logic [ADDR_WIDTH-1:0] buf_addr;
  logic [DATA_WIDTH-1:0] buf_data;
  logic [AGE_W-1:0]      buf_age;
  logic                  buf_match;

  slot_e                 slot;
  logic                  force_wr, wr_accept, drain, fwd_any, rd_accept;
  logic [DATA_WIDTH-1:0] fwd_word;

  logic [ADDR_WIDTH-1:0] addr_1_q, addr_1_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  we_n_q, we_n_d;
  logic                  rd_vld_p1_q, rd_vld_p1_d;
  logic                  rd_fwd_p1_q, rd_fwd_p1_d;
  logic [DATA_WIDTH-1:0] rd_fwd_data_p1_q, rd_fwd_data_p1_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

  write_buffer #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_wbuf (
    .clk        (clk),
    .reset_n    (reset_n),
    .accept     (wr_accept),
    .acc_addr   (wr_addr),
    .acc_data   (wr_data),
    .drain      (drain),
    .match_addr (rd_addr),
    .valid      (buf_valid),
    .addr       (buf_addr),
    .data       (buf_data),
    .age        (buf_age),
    .match      (buf_match)
  );

  // Slot arbitration. A full buffer with a new write pending always drains,
  // so the write grant never depends on the read side (no comb loop).
  always_comb begin
    force_wr  = buf_valid && ((buf_age >= STARVE_AGE) || wr_req);
    wr_accept = wr_req && (!buf_valid || force_wr);
    fwd_any   = rd_req && ((wr_accept && (wr_addr == rd_addr)) || buf_match);
    fwd_word  = (wr_accept && (wr_addr == rd_addr)) ? wr_data : buf_data;
    if (force_wr)                slot = SLOT_WR;
    else if (rd_req && !fwd_any) slot = SLOT_RD;
    else if (buf_valid)          slot = SLOT_WR;
    else                         slot = SLOT_IDLE;
    drain     = (slot == SLOT_WR);
    rd_accept = rd_req && ((slot == SLOT_RD) || fwd_any);
  end

  // SRAM pin drive for next cycle and the two-stage read return path.
  always_comb begin
    addr_1_d   = addr_1_q;
    data_out_d = data_out_q;
    we_n_d     = 1'b1;
    unique case (slot)
      SLOT_RD: addr_1_d = rd_addr;
      SLOT_WR: begin
        addr_1_d   = buf_addr;
        data_out_d = buf_data;
        we_n_d     = 1'b0;
      end
      default: ;
    endcase
    rd_vld_p1_d      = rd_accept && !flush;
    rd_fwd_p1_d      = fwd_any;
    rd_fwd_data_p1_d = fwd_word;
    rd_valid_d       = rd_vld_p1_q && !flush;
    rd_data_d        = rd_data_q;
    if (rd_vld_p1_q) rd_data_d = rd_fwd_p1_q ? rd_fwd_data_p1_q : data_in;
  end

  // Control and pin registers; reset parks the SRAM in read mode at 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_1_q    <= '0;
      data_out_q  <= '0;
      we_n_q      <= 1'b1;
      rd_vld_p1_q <= 1'b0;
      rd_fwd_p1_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      addr_1_q    <= addr_1_d;
      data_out_q  <= data_out_d;
      we_n_q      <= we_n_d;
      rd_vld_p1_q <= rd_vld_p1_d;
      rd_fwd_p1_q <= rd_fwd_p1_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
    end
  end

  // Forwarded word rides along with stage-1 valid, no reset needed.
  always_ff @(posedge clk) begin
    rd_fwd_data_p1_q <= rd_fwd_data_p1_d;
  end

  assign rd_gnt     = rd_accept;
  assign wr_gnt     = wr_accept;
  assign rd_valid   = rd_valid_q;
  assign rd_data    = rd_data_q;
  assign wb_pending = buf_valid;
  assign addr_1     = addr_1_q;
  assign data_out   = data_out_q;
  assign we_n       = we_n_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed scenarios plus random traffic checked
// against an architectural model (golden memory in acceptance order, return
// queue with due cycles) and the arbitration rules.
module tb_data_mem_arbiter;
  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int LIM = 4;
  localparam int S_IDLE = 0;
  localparam int S_RD   = 1;
  localparam int S_WR   = 2;

  logic          clk;
  logic          reset_n;
  logic          rd_req, wr_req, flush;
  logic [AW-1:0] rd_addr, wr_addr, addr_1;
  logic [DW-1:0] wr_data, rd_data, data_out, data_in;
  logic          rd_gnt, rd_valid, wr_gnt, wb_pending, we_n;

  data_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .reset_n(reset_n),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .flush(flush), .wb_pending(wb_pending),
    .addr_1(addr_1), .data_out(data_out), .we_n(we_n), .data_in(data_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] sram [0:65535];
  logic [DW-1:0] gold [0:65535];
  assign data_in = sram[addr_1];

  typedef struct { int due; logic [DW-1:0] data; } ret_t;
  ret_t retq[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic          m_bv;
  logic [AW-1:0] m_ba, m_la;
  logic [DW-1:0] m_bd, m_ld;
  int            m_age, m_prev;

  logic          obs_rgnt, obs_wgnt, obs_wen, obs_rvalid;
  logic [AW-1:0] obs_addr1;
  logic [DW-1:0] obs_rdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock cycle: drive, check against the model, advance model and SRAM.
  task automatic step(input logic rq, input logic [AW-1:0] ra, input logic wq,
                      input logic [AW-1:0] wa, input logic [DW-1:0] wd, input logic fl);
    logic force_wr, exp_wg, exp_rg, fwd;
    int slot;
    logic c_we;
    logic [AW-1:0] c_a;
    logic [DW-1:0] c_d;
    @(negedge clk);
    rd_req = rq; rd_addr = ra; wr_req = wq; wr_addr = wa; wr_data = wd; flush = fl;
    #1;
    obs_rgnt = rd_gnt; obs_wgnt = wr_gnt; obs_wen = we_n; obs_rvalid = rd_valid;
    obs_addr1 = addr_1; obs_rdata = rd_data;
    check("wb_pending", 32'(wb_pending), 32'(m_bv));
    check("we_n", 32'(we_n), 32'(m_prev != S_WR));
    if (m_prev != S_IDLE) check("addr_1", 32'(addr_1), 32'(m_la));
    if (m_prev == S_WR) check("data_out", 32'(data_out), 32'(m_ld));
    if (retq.size() > 0 && retq[0].due == cyc) begin
      check("rd_valid", 32'(rd_valid), 32'd1);
      check("rd_data", 32'(rd_data), 32'(retq[0].data));
      void'(retq.pop_front());
    end else begin
      check("rd_valid", 32'(rd_valid), 32'd0);
    end
    force_wr = m_bv && ((m_age >= LIM) || wq);
    exp_wg   = wq && (!m_bv || force_wr);
    fwd      = rq && ((exp_wg && (wa == ra)) || (m_bv && (m_ba == ra)));
    if (force_wr)          slot = S_WR;
    else if (rq && !fwd)   slot = S_RD;
    else if (m_bv)         slot = S_WR;
    else                   slot = S_IDLE;
    exp_rg = rq && ((slot == S_RD) || fwd);
    check("wr_gnt", 32'(wr_gnt), 32'(exp_wg));
    check("rd_gnt", 32'(rd_gnt), 32'(exp_rg));
    if (exp_wg) gold[wa] = wd;
    if (exp_rg) retq.push_back('{cyc + 2, gold[ra]});
    if (fl) retq.delete();
    if (slot == S_WR) begin
      m_la = m_ba; m_ld = m_bd; m_bv = 1'b0; m_age = 0;
    end else if (m_bv) begin
      m_age = (m_age < 15) ? m_age + 1 : 15;
    end
    if (slot == S_RD) m_la = ra;
    if (exp_wg) begin
      m_bv = 1'b1; m_ba = wa; m_bd = wd; m_age = 0;
    end
    m_prev = slot;
    c_we = !we_n; c_a = addr_1; c_d = data_out;
    @(posedge clk);
    #1;
    if (c_we) sram[c_a] = c_d;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  // Asynchronous reset in the middle of a cycle, held for two clocks.
  task automatic do_reset();
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_we_n", 32'(we_n), 32'd1);
    check("rst_addr_1", 32'(addr_1), 32'd0);
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_wb_pending", 32'(wb_pending), 32'd0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      #1;
      check("rst_hold_we_n", 32'(we_n), 32'd1);
    end
    rd_req = 1'b0; wr_req = 1'b0; flush = 1'b0;
    reset_n = 1'b1;
    for (int i = 0; i < 65536; i++) gold[i] = sram[i];
    retq.delete();
    m_bv = 1'b0; m_age = 0; m_prev = S_IDLE;
  endtask

  initial begin
    int lost, wen_low, nbad;
    reset_n = 1'b0; rd_req = 1'b0; wr_req = 1'b0; flush = 1'b0;
    rd_addr = '0; wr_addr = '0; wr_data = '0;
    for (int i = 0; i < 65536; i++) sram[i] = DW'(i * 40503) ^ 16'h5a5a;
    sram[16'h0010] = 16'hBEEF;
    sram[16'h0030] = 16'h5555;
    for (int i = 0; i < 65536; i++) gold[i] = sram[i];
    m_bv = 1'b0; m_ba = '0; m_bd = '0; m_age = 0; m_prev = S_IDLE; m_la = '0; m_ld = '0;
    #12;
    check("init_we_n", 32'(we_n), 32'd1);
    check("init_addr_1", 32'(addr_1), 32'd0);
    check("init_rd_valid", 32'(rd_valid), 32'd0);
    check("init_wb_pending", 32'(wb_pending), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Single read from SRAM.
    step(1'b1, 16'h0010, 1'b0, '0, '0, 1'b0);
    check("single_gnt", 32'(obs_rgnt), 32'd1);
    idle(1);
    check("single_addr_1", 32'(obs_addr1), 32'h0010);
    check("single_we_n", 32'(obs_wen), 32'd1);
    idle(1);
    check("single_valid", 32'(obs_rvalid), 32'd1);
    check("single_data", 32'(obs_rdata), 32'hBEEF);

    // Posted write drains two cycles later.
    step(1'b0, '0, 1'b1, 16'h0020, 16'h1234, 1'b0);
    check("drain_wr_gnt", 32'(obs_wgnt), 32'd1);
    idle(2);
    check("drain_we_n", 32'(obs_wen), 32'd0);
    check("drain_addr_1", 32'(obs_addr1), 32'h0020);
    check("drain_mem", 32'(sram[16'h0020]), 32'h1234);

    // Same-cycle write and read forward the new word.
    step(1'b1, 16'h0030, 1'b1, 16'h0030, 16'hAAAA, 1'b0);
    idle(2);
    check("fwd_valid", 32'(obs_rvalid), 32'd1);
    check("fwd_data", 32'(obs_rdata), 32'hAAAA);

    // Starvation: continuous reads must still let the write out once.
    idle(3);
    step(1'b1, 16'h0041, 1'b1, 16'h0040, 16'h7777, 1'b0);
    lost = 0; wen_low = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, AW'(16'h0042 + i), 1'b0, '0, '0, 1'b0);
      if (!obs_rgnt) lost++;
      if (!obs_wen) wen_low++;
    end
    check("starve_lost", 32'(lost), 32'd1);
    check("starve_drain", 32'(wen_low), 32'd1);
    check("starve_mem", 32'(sram[16'h0040]), 32'h7777);

    // Flush kills both in-flight reads but not the buffered write.
    idle(3);
    step(1'b1, 16'h0051, 1'b1, 16'h0050, 16'h9999, 1'b0);
    step(1'b1, 16'h0052, 1'b0, '0, '0, 1'b1);
    idle(1);
    check("flush_valid_c2", 32'(obs_rvalid), 32'd0);
    idle(1);
    check("flush_valid_c3", 32'(obs_rvalid), 32'd0);
    check("flush_drain", 32'(obs_wen), 32'd0);
    check("flush_mem", 32'(sram[16'h0050]), 32'h9999);

    // Random traffic over a small address window, with one mid-run reset.
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) do_reset();
      step($urandom_range(99) < 70, AW'($urandom_range(7)),
           $urandom_range(99) < 40, AW'($urandom_range(7)), DW'($urandom),
           $urandom_range(99) < 5);
    end
    idle(6);
    nbad = 0;
    for (int i = 0; i < 256; i++) if (sram[i] !== gold[i]) nbad++;
    check("mem_consistency", 32'(nbad), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
